// File: rtl/hpdcache_pkg.sv
// HPDcache request/response types seen by the hardware prefetcher.
// Only the fields the prefetch path touches are modelled here.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_TID_WIDTH  = 4;
    localparam int unsigned HPDCACHE_ADDR_WIDTH = 32;
    localparam int unsigned HPDCACHE_DATA_WIDTH = 32;

    typedef logic [HPDCACHE_TID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef enum logic [1:0] {
        HPDCACHE_REQ_LOAD  = 2'd0,
        HPDCACHE_REQ_STORE = 2'd1,
        HPDCACHE_REQ_CMO   = 2'd2
    } hpdcache_req_op_t;

    typedef struct packed {
        logic [HPDCACHE_ADDR_WIDTH-1:0] addr;
        hpdcache_req_op_t               op;
        logic [2:0]                     size;
        logic                           need_rsp;
        hpdcache_req_tid_t              tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [HPDCACHE_DATA_WIDTH-1:0] rdata;
        logic                           error;
        logic                           aborted;
        hpdcache_req_tid_t              tid;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hwpf_stride_pkg.sv
// Shared definitions for the stride prefetcher and its request arbiter.
package hwpf_stride_pkg;

    import hpdcache_pkg::*;

    // The tid stamped on each request identifies the engine, so the tid
    // width bounds how many engines can share the dcache port.
    localparam int unsigned HWPF_ARB_IDX_MAX_W   = $bits(hpdcache_req_tid_t);
    localparam int unsigned HWPF_ARB_MAX_ENGINES = 2 ** HWPF_ARB_IDX_MAX_W;

    // Engine index wide enough for the largest legal arbiter.
    typedef logic [HWPF_ARB_IDX_MAX_W-1:0] hwpf_arb_idx_t;

    // Index/pointer width for a given engine count (at least one bit).
    function automatic int unsigned hwpf_arb_idx_width(input int unsigned num_engines);
        if (num_engines > 32'd1) begin
            return $clog2(num_engines);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/hwpf_rr_arbiter.sv
// Round-robin priority selector: picks the first asserted request at or
// after ptr_i, wrapping modulo NUM_REQ. Purely combinational.
module hwpf_rr_arbiter
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = hwpf_arb_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int unsigned SUM_W = IDX_W + 32'd1;

    logic [SUM_W-1:0] sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest valid request wins.
    always_comb begin
        idx_o  = '0;
        any_o  = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            sum_s = {1'b0, ptr_i} + SUM_W'(off);
            if (sum_s >= SUM_W'(NUM_REQ)) begin
                sum_s = sum_s - SUM_W'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (req_i[cand_s]) begin
                idx_o = cand_s;
                any_o = 1'b1;
            end else begin
                idx_o = idx_o;
                any_o = any_o;
            end
        end
    end

    // Expand the winning index into a one-hot grant vector.
    always_comb begin
        gnt_o = '0;
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/hwpf_stride_arb_sva.sv
// Protocol checker for the prefetch request arbiter.
module hwpf_stride_arb_sva
    import hpdcache_pkg::*;
#(
    parameter int unsigned NUM_HW_PREFETCH = 4
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    input logic [NUM_HW_PREFETCH-1:0] req_ready,
    input logic                       dcache_req_valid,
    input logic                       dcache_req_ready,
    input hpdcache_req_t              dcache_req
);

    // At most one engine is granted in any cycle.
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready));

    // A stalled request must neither change nor be withdrawn.
    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dcache_req_valid && !dcache_req_ready) |=> (dcache_req_valid && $stable(dcache_req)));

endmodule

// File: rtl/hwpf_stride_arb.sv
// Arbitrates the stride engines' prefetch requests onto the single
// HPDcache prefetch port, stamping tid with the engine index, and routes
// responses back to the engine whose index matches the response tid.
module hwpf_stride_arb
    import hpdcache_pkg::*;
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_HW_PREFETCH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [NUM_HW_PREFETCH-1:0] hwpf_req_valid_i,
    output logic [NUM_HW_PREFETCH-1:0] hwpf_req_ready_o,
    input  hpdcache_req_t              hwpf_req_i [NUM_HW_PREFETCH-1:0],
    output logic [NUM_HW_PREFETCH-1:0] hwpf_rsp_valid_o,
    output hpdcache_rsp_t              hwpf_rsp_o,

    output logic                       dcache_req_valid_o,
    input  logic                       dcache_req_ready_i,
    output hpdcache_req_t              dcache_req_o,
    input  logic                       dcache_rsp_valid_i,
    input  hpdcache_rsp_t              dcache_rsp_i,

    output logic                       tid_err_o
);

    localparam int unsigned IDX_W = hwpf_arb_idx_width(NUM_HW_PREFETCH);

    if ((NUM_HW_PREFETCH < 32'd1) || (NUM_HW_PREFETCH > HWPF_ARB_MAX_ENGINES)) begin : g_bad_num_engines
        $error("hwpf_stride_arb: NUM_HW_PREFETCH must be in 1..2^$bits(hpdcache_req_tid_t)");
    end

    logic [IDX_W-1:0]           rr_ptr_r;
    logic [IDX_W-1:0]           rr_ptr_nxt_s;
    logic [IDX_W-1:0]           arb_idx_s;
    logic [NUM_HW_PREFETCH-1:0] arb_gnt_s;
    logic                       arb_any_s;
    logic                       slot_free_s;
    logic                       grant_s;
    logic                       out_valid_r;
    hpdcache_req_t              out_req_r;
    hpdcache_req_t              stamped_req_s;
    logic                       tid_oor_s;
    logic                       tid_err_r;

    hwpf_rr_arbiter #(
        .NUM_REQ (NUM_HW_PREFETCH),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i (hwpf_req_valid_i),
        .ptr_i (rr_ptr_r),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .any_o (arb_any_s)
    );

    // The output slot accepts a new request when empty or draining this cycle.
    always_comb begin
        slot_free_s = !out_valid_r || dcache_req_ready_i;
        grant_s     = slot_free_s && arb_any_s;
    end

    // Grant goes only to the arbitration winner, and only if it can be stored.
    always_comb begin
        hwpf_req_ready_o = '0;
        if (grant_s) begin
            hwpf_req_ready_o = arb_gnt_s;
        end else begin
            hwpf_req_ready_o = '0;
        end
    end

    // Winner's payload with tid replaced by the engine index.
    always_comb begin
        stamped_req_s     = hwpf_req_i[arb_idx_s];
        stamped_req_s.tid = hpdcache_req_tid_t'(arb_idx_s);
    end

    // Pointer moves just past the winner, wrapping at the last engine.
    always_comb begin
        rr_ptr_nxt_s = '0;
        if (arb_idx_s == IDX_W'(NUM_HW_PREFETCH - 32'd1)) begin
            rr_ptr_nxt_s = '0;
        end else begin
            rr_ptr_nxt_s = arb_idx_s + IDX_W'(1);
        end
    end

    // Output stage: capture on grant, empty on accept, hold while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_req_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (grant_s) begin
            out_valid_r <= 1'b1;
            out_req_r   <= stamped_req_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
        end else if (dcache_req_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign dcache_req_valid_o = out_valid_r;
    assign dcache_req_o       = out_req_r;

    // Response tids beyond the engine count cannot be routed anywhere.
    always_comb begin
        tid_oor_s = 1'b0;
        if (32'(dcache_rsp_i.tid) >= 32'(NUM_HW_PREFETCH)) begin
            tid_oor_s = 1'b1;
        end else begin
            tid_oor_s = 1'b0;
        end
    end

    // Sticky record of an unroutable response, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tid_err_r <= 1'b0;
        end else if (dcache_rsp_valid_i && tid_oor_s) begin
            tid_err_r <= 1'b1;
        end else begin
            tid_err_r <= tid_err_r;
        end
    end

    assign tid_err_o = tid_err_r;

    // Response demux: the engine whose index equals the tid sees the valid.
    for (genvar g = 0; g < NUM_HW_PREFETCH; g++) begin : g_rsp_demux
        assign hwpf_rsp_valid_o[g] = dcache_rsp_valid_i && (32'(dcache_rsp_i.tid) == 32'(g));
    end

    assign hwpf_rsp_o = dcache_rsp_i;

    hwpf_stride_arb_sva #(
        .NUM_HW_PREFETCH (NUM_HW_PREFETCH)
    ) u_sva (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_ready        (hwpf_req_ready_o),
        .dcache_req_valid (dcache_req_valid_o),
        .dcache_req_ready (dcache_req_ready_i),
        .dcache_req       (dcache_req_o)
    );

endmodule

// File: tb/tb_hwpf_stride_arb.sv
// Directed bench for hwpf_stride_arb: a 4-engine instance for arbitration,
// backpressure, routing and reset, and a 3-engine instance for bad tids.
module tb_hwpf_stride_arb;

    import hpdcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [3:0]    req_valid4;
    logic [3:0]    req_ready4;
    hpdcache_req_t req4 [3:0];
    logic [3:0]    rsp_valid4;
    hpdcache_rsp_t rsp_o4;
    logic          dreq_valid4;
    logic          dready4;
    hpdcache_req_t dreq4;
    logic          drsp_valid4;
    hpdcache_rsp_t rsp_i4;
    logic          tid_err4;

    logic [2:0]    req_valid3;
    logic [2:0]    req_ready3;
    hpdcache_req_t req3 [2:0];
    logic [2:0]    rsp_valid3;
    hpdcache_rsp_t rsp_o3;
    logic          dreq_valid3;
    logic          dready3;
    hpdcache_req_t dreq3;
    logic          drsp_valid3;
    hpdcache_rsp_t rsp_i3;
    logic          tid_err3;

    int checks = 0;
    int errors = 0;

    hwpf_stride_arb #(.NUM_HW_PREFETCH(4)) u_dut4 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .hwpf_req_valid_i   (req_valid4),
        .hwpf_req_ready_o   (req_ready4),
        .hwpf_req_i         (req4),
        .hwpf_rsp_valid_o   (rsp_valid4),
        .hwpf_rsp_o         (rsp_o4),
        .dcache_req_valid_o (dreq_valid4),
        .dcache_req_ready_i (dready4),
        .dcache_req_o       (dreq4),
        .dcache_rsp_valid_i (drsp_valid4),
        .dcache_rsp_i       (rsp_i4),
        .tid_err_o          (tid_err4)
    );

    hwpf_stride_arb #(.NUM_HW_PREFETCH(3)) u_dut3 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .hwpf_req_valid_i   (req_valid3),
        .hwpf_req_ready_o   (req_ready3),
        .hwpf_req_i         (req3),
        .hwpf_rsp_valid_o   (rsp_valid3),
        .hwpf_rsp_o         (rsp_o3),
        .dcache_req_valid_o (dreq_valid3),
        .dcache_req_ready_i (dready3),
        .dcache_req_o       (dreq3),
        .dcache_rsp_valid_i (drsp_valid3),
        .dcache_rsp_i       (rsp_i3),
        .tid_err_o          (tid_err3)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid4  = 4'b0000;
        dready4     = 1'b0;
        drsp_valid4 = 1'b0;
        rsp_i4      = '0;
        for (int i = 0; i < 4; i++) begin
            req4[i] = '0;
        end
        req_valid3  = 3'b000;
        dready3     = 1'b1;
        drsp_valid3 = 1'b0;
        rsp_i3      = '0;
        for (int i = 0; i < 3; i++) begin
            req3[i] = '0;
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic [3:0] exp_tid;

        rst_n = 1'b0;
        clear_inputs();

        // Reset state
        #3;
        check_eq("rst_dreq_valid", 64'(dreq_valid4), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready4), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid4), 64'd0);
        check_eq("rst_tid_err", 64'(tid_err4), 64'd0);
        check_eq("rst_dreq_payload", 64'(dreq4), 64'd0);
        check_eq("rst_tid_err3", 64'(tid_err3), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from engine 2; incoming tid must be overwritten
        req4[2].addr = 32'h0000_1000;
        req4[2].op   = HPDCACHE_REQ_CMO;
        req4[2].size = 3'd6;
        req4[2].tid  = 4'hF;
        req_valid4   = 4'b0100;
        dready4      = 1'b1;
        #1;
        check_eq("single_ready", 64'(req_ready4), 64'h4);
        @(posedge clk);
        #1;
        check_eq("single_valid", 64'(dreq_valid4), 64'd1);
        check_eq("single_addr", 64'(dreq4.addr), 64'h1000);
        check_eq("single_tid", 64'(dreq4.tid), 64'd2);
        check_eq("single_size", 64'(dreq4.size), 64'd6);
        check_eq("single_op", 64'(dreq4.op), 64'(HPDCACHE_REQ_CMO));
        @(negedge clk);
        req_valid4 = 4'b0000;
        #1;
        check_eq("single_ready_drop", 64'(req_ready4), 64'd0);
        @(posedge clk);
        #1;
        check_eq("single_drain", 64'(dreq_valid4), 64'd0);

        // Fresh reset so the pointer restarts at 0, then all engines valid
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req4[i]      = '0;
            req4[i].addr = 32'h0000_2000 + 32'(i) * 32'h40;
            req4[i].op   = HPDCACHE_REQ_CMO;
        end
        req_valid4 = 4'b1111;
        dready4    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            exp_tid = 4'(k % 4);
            #1;
            check_eq("rr_ready", 64'(req_ready4), 64'(exp_gnt));
            @(posedge clk);
            #1;
            check_eq("rr_valid", 64'(dreq_valid4), 64'd1);
            check_eq("rr_tid", 64'(dreq4.tid), 64'(exp_tid));
            check_eq("rr_addr", 64'(dreq4.addr), 64'(32'h0000_2000 + 32'(exp_tid) * 32'h40));
            @(negedge clk);
        end
        req_valid4 = 4'b0000;
        @(posedge clk);
        #1;
        check_eq("rr_drain", 64'(dreq_valid4), 64'd0);

        // Backpressure with engines 0 and 3 valid (pointer is back at 0)
        @(negedge clk);
        req4[0].addr = 32'h0000_3000;
        req4[3].addr = 32'h0000_3300;
        req_valid4   = 4'b1001;
        dready4      = 1'b0;
        #1;
        check_eq("bp_first_ready", 64'(req_ready4), 64'h1);
        @(posedge clk);
        #1;
        check_eq("bp_first_valid", 64'(dreq_valid4), 64'd1);
        check_eq("bp_first_tid", 64'(dreq4.tid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check_eq("bp_stall_ready", 64'(req_ready4), 64'd0);
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", 64'(dreq_valid4), 64'd1);
            check_eq("bp_hold_tid", 64'(dreq4.tid), 64'd0);
            check_eq("bp_hold_addr", 64'(dreq4.addr), 64'h3000);
        end
        @(negedge clk);
        dready4 = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(req_ready4), 64'h8);
        @(posedge clk);
        #1;
        check_eq("bp_next_valid", 64'(dreq_valid4), 64'd1);
        check_eq("bp_next_tid", 64'(dreq4.tid), 64'd3);
        check_eq("bp_next_addr", 64'(dreq4.addr), 64'h3300);
        @(negedge clk);
        req_valid4 = 4'b0000;
        @(posedge clk);
        #1;
        check_eq("bp_drain", 64'(dreq_valid4), 64'd0);

        // Response routing on the 4-engine instance
        @(negedge clk);
        drsp_valid4  = 1'b1;
        rsp_i4.tid   = 4'd1;
        rsp_i4.rdata = 32'hCAFE_0001;
        #1;
        check_eq("rsp_tid1", 64'(rsp_valid4), 64'h2);
        check_eq("rsp_data", 64'(rsp_o4.rdata), 64'hCAFE_0001);
        @(negedge clk);
        rsp_i4.tid = 4'd3;
        #1;
        check_eq("rsp_tid3", 64'(rsp_valid4), 64'h8);
        @(negedge clk);
        drsp_valid4 = 1'b0;
        rsp_i4.tid  = 4'd2;
        #1;
        check_eq("rsp_novalid", 64'(rsp_valid4), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rsp_no_err", 64'(tid_err4), 64'd0);

        // Out-of-range tid on the 3-engine instance
        @(negedge clk);
        drsp_valid3 = 1'b1;
        rsp_i3.tid  = 4'd2;
        #1;
        check_eq("rsp3_tid2", 64'(rsp_valid3), 64'h4);
        @(negedge clk);
        rsp_i3.tid = 4'd3;
        #1;
        check_eq("rsp3_bad_route", 64'(rsp_valid3), 64'd0);
        check_eq("rsp3_err_before", 64'(tid_err3), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rsp3_err_set", 64'(tid_err3), 64'd1);
        @(negedge clk);
        drsp_valid3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rsp3_err_sticky", 64'(tid_err3), 64'd1);
        check_eq("rsp3_err_isolated", 64'(tid_err4), 64'd0);

        // Out-of-range tid on the 4-engine instance
        @(negedge clk);
        drsp_valid4 = 1'b1;
        rsp_i4.tid  = 4'd4;
        #1;
        check_eq("rsp4_bad_route", 64'(rsp_valid4), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rsp4_err_set", 64'(tid_err4), 64'd1);
        @(negedge clk);
        drsp_valid4 = 1'b0;

        // Reset while a request is stalled in the output register
        req4[1].addr = 32'h0000_4100;
        req4[2].addr = 32'h0000_4200;
        req_valid4   = 4'b0110;
        dready4      = 1'b0;
        #1;
        check_eq("mid_ready", 64'(req_ready4), 64'h2);
        @(posedge clk);
        #1;
        check_eq("mid_valid", 64'(dreq_valid4), 64'd1);
        check_eq("mid_tid", 64'(dreq4.tid), 64'd1);
        #2;
        rst_n      = 1'b0;
        req_valid4 = 4'b0000;
        #1;
        check_eq("mid_rst_valid", 64'(dreq_valid4), 64'd0);
        check_eq("mid_rst_payload", 64'(dreq4), 64'd0);
        check_eq("mid_rst_ready", 64'(req_ready4), 64'd0);
        check_eq("mid_rst_err3", 64'(tid_err3), 64'd0);
        check_eq("mid_rst_err4", 64'(tid_err4), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        req_valid4 = 4'b0110;
        dready4    = 1'b1;
        #1;
        check_eq("post_rst_ready", 64'(req_ready4), 64'h2);
        @(posedge clk);
        #1;
        check_eq("post_rst_valid", 64'(dreq_valid4), 64'd1);
        check_eq("post_rst_tid", 64'(dreq4.tid), 64'd1);
        check_eq("post_rst_addr", 64'(dreq4.addr), 64'h4100);
        @(negedge clk);
        req_valid4 = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
